// File: rtl/leb128_pkg.sv
// leb128_pkg: constants, length type and FSM states shared by the LEB128 encoder and decoder.
package leb128_pkg;

    localparam int LEB_GROUP_W  = 7;
    localparam int LEB_CONT_BIT = 7;

    typedef logic [3:0] leb_len_t;

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } leb_tx_state_t;

    function automatic int leb_max_bytes(input int n);
        return (n + LEB_GROUP_W - 1) / LEB_GROUP_W;
    endfunction

endpackage

// File: rtl/leb_size_u64.sv
// leb_size_u64: minimal LEB128 byte count of an N-bit value (1 + index of highest nonzero 7-bit group).
module leb_size_u64
    import leb128_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [N-1:0] value_i,
    output logic [3:0]   nb_o
);

    localparam int MB = leb_max_bytes(N);
    localparam int EW = MB * LEB_GROUP_W;

    logic [EW-1:0] ext;

    assign ext = EW'(value_i);

    // Zero still needs one byte, so the count starts at 1 and later groups override it.
    always_comb begin
        nb_o = 4'd1;
        for (int i = 1; i < MB; i++) begin
            if (ext[i*LEB_GROUP_W +: LEB_GROUP_W] != '0) nb_o = leb_len_t'(i + 1);
        end
    end

endmodule

// File: rtl/pack_u64_serial.sv
// pack_u64_serial: streaming unsigned LEB128 encoder, one byte per clock, low group first.
module pack_u64_serial
    import leb128_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic [3:0]   out_len
);

    leb_tx_state_t state_q, state_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    len_q, len_d;
    logic [7:0]    data_q, data_d;
    logic          last_q, last_d;
    logic [3:0]    nb;
    logic          accept, advance, done, next_last;

    leb_size_u64 #(.N(N)) u_size (
        .value_i (in),
        .nb_o    (nb)
    );

    assign out_valid = state_q == S_EMIT;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_len   = len_q;
    assign in_ready  = (state_q == S_IDLE || (out_valid && last_q && out_ready)) && !rst;
    assign accept    = in_valid && in_ready;
    assign advance   = out_valid && out_ready && !last_q;
    assign done      = out_valid && out_ready && last_q;
    assign next_last = cnt_q + 4'd2 == len_q;

    // rem_q holds the groups not yet presented, so the next byte is always its low group.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        data_d  = data_q;
        last_d  = last_q;
        if (accept) begin
            state_d = S_EMIT;
            rem_d   = in >> LEB_GROUP_W;
            cnt_d   = '0;
            len_d   = nb;
            last_d  = nb == 4'd1;
            data_d  = {nb != 4'd1, in[LEB_GROUP_W-1:0]};
        end else if (advance) begin
            rem_d   = rem_q >> LEB_GROUP_W;
            cnt_d   = cnt_q + 4'd1;
            last_d  = next_last;
            data_d  = {!next_last, rem_q[LEB_GROUP_W-1:0]};
        end else if (done) begin
            state_d = S_IDLE;
            rem_d   = '0;
            cnt_d   = '0;
            len_d   = '0;
            last_d  = 1'b0;
            data_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_pack_u64_serial.sv
// tb_pack_u64_serial: directed table-driven bench for the streaming LEB128 encoder.
module tb_pack_u64_serial;

    typedef struct {
        logic [63:0] value;
        logic [79:0] bus;
        int          nb;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] in_v = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic [3:0]  out_len;

    int pass_cnt = 0;
    int total_cnt = 0;

    vec_t vecs[9];

    pack_u64_serial #(.N(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in_v),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_len   (out_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] leb_decode(input logic [79:0] bus, output int len);
        logic [63:0] v;
        logic [7:0]  b;
        v = '0;
        len = 0;
        for (int i = 0; i < 10; i++) begin
            b = bus[8*i +: 8];
            v = v | (64'(b[6:0]) << (7 * i));
            len = i + 1;
            if (!b[7]) break;
        end
        return v;
    endfunction

    task automatic encode(input logic [63:0] v, input logic [79:0] exp_bus, input int exp_nb);
        logic [79:0] got;
        int          n;
        int          waits;
        int          dlen;
        logic [63:0] dval;
        got = '0;
        n = 0;
        waits = 0;
        in_v = v;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        while (!in_ready && waits < 20) begin
            @(negedge clk);
            #1;
            waits++;
        end
        check($sformatf("in_ready %0h", v), 80'(in_ready), 80'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        for (int k = 0; k < 12; k++) begin
            if (!out_valid) begin
                check($sformatf("out_valid %0h byte %0d", v, k), 80'(out_valid), 80'd1);
                break;
            end
            got[8*n +: 8] = out_data;
            check($sformatf("byte %0h[%0d]", v, k), 80'(out_data), 80'(exp_bus[8*k +: 8]));
            check($sformatf("last %0h[%0d]", v, k), 80'(out_last), 80'(k == exp_nb - 1));
            check($sformatf("len %0h[%0d]", v, k), 80'(out_len), 80'(exp_nb));
            n++;
            if (out_last) break;
            @(negedge clk);
            #1;
        end
        check($sformatf("handshakes %0h", v), 80'(n), 80'(exp_nb));
        check($sformatf("bus %0h", v), got, exp_bus);
        dval = leb_decode(got, dlen);
        check($sformatf("decode %0h", v), 80'(dval), 80'(v));
        check($sformatf("decode_len %0h", v), 80'(dlen), 80'(exp_nb));
        @(negedge clk);
        #1;
        check($sformatf("idle_after %0h", v), 80'(out_valid), 80'd0);
    endtask

    initial begin
        logic [7:0]  bp_bytes[3];
        logic        bp_pat[6];
        logic [63:0] b2b_vals[3];
        logic [7:0]  b2b_data[4];
        logic        b2b_last[4];
        logic [3:0]  b2b_len[4];
        logic [79:0] cur_bus;
        logic [63:0] dval;
        int          cur_n;
        int          pk;
        int          vi;
        int          idx;
        int          hs;
        int          dlen;

        vecs[0] = '{64'd0,                    80'h00,                      1};
        vecs[1] = '{64'd127,                  80'h7F,                      1};
        vecs[2] = '{64'd128,                  80'h0180,                    2};
        vecs[3] = '{64'd624485,               80'h268EE5,                  3};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF,  80'h01_FFFFFFFFFFFFFFFFFF,   10};
        vecs[5] = '{64'd300,                  80'h02AC,                    2};
        vecs[6] = '{64'h8000_0000_0000_0000,  80'h01_808080808080808080,   10};
        vecs[7] = '{64'd16383,                80'h7FFF,                    2};
        vecs[8] = '{64'd16384,                80'h018080,                  3};

        @(negedge clk);
        #1;
        check("rst in_ready", 80'(in_ready), 80'd0);
        check("rst out_valid", 80'(out_valid), 80'd0);
        check("rst out_data", 80'(out_data), 80'h00);
        check("rst out_last", 80'(out_last), 80'd0);
        check("rst out_len", 80'(out_len), 80'd0);
        rst = 1'b0;
        #1;
        check("release in_ready", 80'(in_ready), 80'd1);

        for (int i = 0; i < 9; i++) encode(vecs[i].value, vecs[i].bus, vecs[i].nb);

        bp_bytes = '{8'hE5, 8'h8E, 8'h26};
        bp_pat   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        in_v = 64'd624485;
        in_valid = 1'b1;
        out_ready = 1'b0;
        #1;
        check("bp accept ready", 80'(in_ready), 80'd1);
        @(negedge clk);
        in_valid = 1'b0;
        idx = 0;
        hs = 0;
        for (int p = 0; p < 6; p++) begin
            out_ready = bp_pat[p];
            #1;
            check($sformatf("bp valid c%0d", p), 80'(out_valid), 80'd1);
            check($sformatf("bp data c%0d", p), 80'(out_data), 80'(bp_bytes[idx]));
            check($sformatf("bp in_ready c%0d", p), 80'(in_ready), 80'(bp_pat[p] && idx == 2));
            if (bp_pat[p]) begin
                hs++;
                if (idx < 2) idx++;
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp handshakes", 80'(hs), 80'd3);
        check("bp idle", 80'(out_valid), 80'd0);

        b2b_vals = '{64'd1, 64'd300, 64'd0};
        b2b_data = '{8'h01, 8'hAC, 8'h02, 8'h00};
        b2b_last = '{1'b1, 1'b0, 1'b1, 1'b1};
        b2b_len  = '{4'd1, 4'd2, 4'd2, 4'd1};
        @(negedge clk);
        in_v = b2b_vals[0];
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        check("b2b accept ready", 80'(in_ready), 80'd1);
        vi = 1;
        pk = 0;
        cur_n = 0;
        cur_bus = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("b2b valid %0d", k), 80'(out_valid), 80'd1);
            check($sformatf("b2b data %0d", k), 80'(out_data), 80'(b2b_data[k]));
            check($sformatf("b2b last %0d", k), 80'(out_last), 80'(b2b_last[k]));
            check($sformatf("b2b len %0d", k), 80'(out_len), 80'(b2b_len[k]));
            check($sformatf("b2b in_ready %0d", k), 80'(in_ready), 80'(b2b_last[k]));
            cur_bus[8*cur_n +: 8] = out_data;
            cur_n++;
            if (out_last && pk < 3) begin
                dval = leb_decode(cur_bus, dlen);
                check($sformatf("b2b decode %0d", pk), 80'(dval), 80'(b2b_vals[pk]));
                check($sformatf("b2b decode_len %0d", pk), 80'(dlen), 80'(cur_n));
                pk++;
                cur_n = 0;
                cur_bus = '0;
            end
            if (in_ready) begin
                if (vi < 3) begin
                    in_v = b2b_vals[vi];
                    vi++;
                end else in_valid = 1'b0;
            end
        end
        @(negedge clk);
        #1;
        check("b2b idle", 80'(out_valid), 80'd0);

        in_v = 64'h8000_0000_0000_0000;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rmid accept ready", 80'(in_ready), 80'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("rmid byte0", 80'(out_data), 80'h80);
        @(negedge clk);
        #1;
        check("rmid byte1", 80'(out_data), 80'h80);
        check("rmid byte1 valid", 80'(out_valid), 80'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rmid async valid", 80'(out_valid), 80'd0);
        check("rmid async data", 80'(out_data), 80'h00);
        check("rmid async len", 80'(out_len), 80'd0);
        check("rmid async in_ready", 80'(in_ready), 80'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rmid release valid", 80'(out_valid), 80'd0);
        check("rmid release in_ready", 80'(in_ready), 80'd1);
        @(negedge clk);
        #1;
        check("rmid no continuation", 80'(out_valid), 80'd0);
        encode(64'd5, 80'h05, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pack_u64_serial.md
# pack_u64_serial

Streaming unsigned LEB128 encoder: accepts an N-bit unsigned value over a valid/ready handshake and emits its minimal LEB128 encoding one byte per clock, least-significant 7-bit group first. It is the transmit-side counterpart of the `unpack_u64` decoder. Its byte stream, packed byte 0 first into an 80-bit bus, must decode under `unpack_u64` to the original value and length. It sits between value producers and byte-oriented serializers and FIFOs.

## Interface
- `N`, 64: input value width; supported range 8..64; MAX_BYTES = ceil(N/7), which is 10 for N=64.
- `clk`  in  1  clock; rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in`  in  N  unsigned value to encode.
- `in_valid`  in  1  `in` is valid.
- `in_ready`  out  1  encoder accepts `in` this cycle.
- `out_data`  out  8  encoded byte; bit 7 is the continuation (glue) bit, bits 6:0 are the payload group.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts `out_data` this cycle.
- `out_last`  out  1  current byte is the final byte of the value; its bit 7 is 0.
- `out_len`  out  4  total byte count of the current value (1..MAX_BYTES); constant for all bytes of that value.

## Operation
- Group i = value[7i+6:7i], zero-extended above N-1. For N=64, group 9 carries only bit 63.
- Byte count nb = 1 + index of the highest nonzero group; value 0 gives nb = 1.
- Byte i = {i < nb-1, group i}, for i = 0..nb-1. No redundant trailing 0x80/0x00 bytes are produced.
- FSM has two states:
  - IDLE: `out_valid`=0. On `in_valid && in_ready`, the encoder latches the value, computes nb, loads byte 0, and moves to EMIT.
  - EMIT: a byte is presented. On `out_valid && out_ready`:
    - If `out_last`=0: increment the byte index and present the next byte.
    - If `out_last`=1 and `in_valid`: accept the next value in the same cycle and present its byte 0 on the next cycle; stay in EMIT.
    - If `out_last`=1 and no new value: go to IDLE.
- `in_ready` = (state==IDLE || (out_valid && out_last && out_ready)) && !rst. This is the only combinational path from `out_ready`.
- Output stability: while `out_valid && !out_ready`, `out_data`, `out_last` and `out_len` hold. `in` is not sampled outside the accept cycle.
- Width rules:
  - Shift the latched value right by 7 per emitted byte, or index by byte counter. Either is acceptable.
  - The byte counter is 4 bits and never exceeds MAX_BYTES-1.
  - `out_len` = nb.

## Timing
- Reset values: state=IDLE, `out_valid`=0, `out_data`=0x00, `out_last`=0, `out_len`=0, internal value and counter 0. `in_ready`=0 while `rst` is high and 1 in the first cycle after release.
- Latency: for an accept at edge k, byte 0 is valid after edge k, i.e. one cycle.
- Throughput: 1 byte/cycle sustained with `out_ready` held high, including across value boundaries. There is no bubble between the last byte of one value and byte 0 of the next.
- A value of nb bytes occupies exactly nb output handshakes.
- Reset mid-packet: the packet is abandoned immediately, with outputs at reset values asynchronously. No partial continuation occurs after release.
- `in_valid` high during EMIT (not on the last byte) is ignored and held off by `in_ready`=0.
- `out_ready` high while `out_valid`=0 has no effect.

## Structure
- Shared package `leb128_pkg` holds:
  - LEB_GROUP_W = 7
  - LEB_CONT_BIT = 7
  - function `leb_max_bytes(N)` = ceil(N/7)
  - the 4-bit length type shared with `unpack_u64`'s `len`.
- One sub-module: `leb_size_u64`, a combinational group-nonzero priority encoder (value -> nb), instantiated once at the accept path.

## Test plan
- Value 0, `out_ready`=1 → single byte 0x00, `out_last`=1, `out_len`=1, accepted the cycle after reset release.
- Value 127 → 0x7F/last, `out_len`=1. Value 128 → 0x80, 0x01/last, `out_len`=2.
- Value 624485 → 0xE5, 0x8E, 0x26/last, `out_len`=3. Value 0xFFFF_FFFF_FFFF_FFFF → nine 0xFF then 0x01/last, `out_len`=10.
- Backpressure: encode 624485 with `out_ready` pattern 0,1,0,0,1,1 → bytes unchanged while stalled, exactly 3 handshakes, `in_ready` low until the final handshake.
- Back-to-back: values 1, 300, 0 with `in_valid` and `out_ready` held high → 0x01, 0xAC, 0x02, 0x00 on consecutive cycles with no gap. Each packet, zero-packed to 80 bits, decodes under `unpack_u64` to the same value and length.
- Reset mid-packet: assert `rst` after byte 1 of 2^63 → `out_valid` drops asynchronously. After release, a new value 5 emits 0x05/last only.
